codestream_bram_reader: RTL and testbench

- Reads the finished JPEG2000 codestream back out of the CPU-side dual-port BRAM (port B). jpeg2000_top writes this BRAM as 32-bit words at byte addresses stepping by 4.
- Serializes each word MSB byte first onto a valid/ready byte stream for a downstream consumer (UART transmitter or host link).
- Sits beside jpeg2000_top in the top level and shares the port B address, enable and data pins through a top-level mux.
- Started by a single pulse once tier-1/tier-2 coding has finished.

---
 rtl/jpeg_stream_pkg.sv | 28 ++
 rtl/word_byte_serializer.sv | 68 ++++++
 rtl/codestream_bram_reader.sv | 155 +++++++++++++++
 tb/tb_codestream_bram_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpeg_stream_pkg : shared types/constants for codestream readout      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jpeg_stream_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_CNT_W  = 16;

  localparam logic [7:0] MARK_FF     = 8'hFF;
  localparam logic [7:0] MARK_EOC_LO = 8'hD9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  function automatic logic is_eoc(input logic [7:0] prev, input logic [7:0] cur);
    return (prev == MARK_FF) && (cur == MARK_EOC_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_byte_serializer : 32-bit word to MSB-first valid/ready bytes    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module word_byte_serializer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        flush_i,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        fire_o,
  output logic        last_o
);

  logic [31:0] sr_q,    sr_d;
  logic        valid_q, valid_d;
  logic [1:0]  idx_q,   idx_d;
  logic        last_q,  last_d;

  assign fire_o  = valid_q & ready_i;
  assign data_o  = sr_q[31:24];
  assign valid_o = valid_q;
  assign last_o  = last_q;

  always_comb begin
    sr_d    = sr_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = 1'b0;
    if (flush_i) begin
      sr_d    = '0;
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (load_i) begin
      sr_d    = word_i;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (fire_o) begin
      sr_d  = {sr_q[23:0], 8'h00};
      idx_d = idx_q + 2'd1;
      // last_o is a registered pulse the cycle after the 4th byte leaves
      if (idx_q == 2'd3) begin
        valid_d = 1'b0;
        last_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/codestream_bram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | codestream_bram_reader : BRAM port B words -> MSB-first byte stream  |
// | Optional EOC early stop: define CODESTREAM_EOC_STOP_EN               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module codestream_bram_reader
  import jpeg_stream_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [31:0]       bram_dout,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done,
`ifdef CODESTREAM_EOC_STOP_EN
  output logic              eoc_seen,
`endif
  output logic [CNT_W+1:0]  bytes_sent
);

  localparam logic [1:0] WAIT_INIT = 2'((RD_LAT > 2) ? (RD_LAT - 2) : 0);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remain_q;
  logic [1:0]        wait_q;
  logic              bram_en_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W+1:0]  sent_q;
  logic              fire;
  logic              last_byte;
  logic              eoc_hit;
  logic              start_acc;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign bram_en    = bram_en_q;
  assign bram_addr  = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bytes_sent = sent_q;

  word_byte_serializer u_ser (
    .clk_i   (clk_100),
    .rst_i   (rst),
    .load_i  (state_q == ST_LOAD),
    .word_i  (bram_dout),
    .flush_i (eoc_hit),
    .ready_i (byte_ready),
    .data_o  (byte_data),
    .valid_o (byte_valid),
    .fire_o  (fire),
    .last_o  (last_byte)
  );

`ifdef CODESTREAM_EOC_STOP_EN
  logic [7:0] prev_q;
  logic       eoc_q;

  assign eoc_hit  = fire && is_eoc(prev_q, byte_data);
  assign eoc_seen = eoc_q;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      prev_q <= '0;
      eoc_q  <= 1'b0;
    end else if (start_acc) begin
      prev_q <= '0;
      eoc_q  <= 1'b0;
    end else if (fire) begin
      prev_q <= byte_data;
      if (eoc_hit) eoc_q <= 1'b1;
    end
  end
`else
  assign eoc_hit = 1'b0;
`endif

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      wait_q    <= '0;
      bram_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
    end else begin
      bram_en_q <= 1'b0;
      done_q    <= 1'b0;
      if (fire) sent_q <= sent_q + (CNT_W+2)'(1);
      case (state_q)
        ST_IDLE: begin
          // busy stays up through the done cycle and drops after it
          busy_q <= 1'b0;
          if (start) begin
            busy_q   <= 1'b1;
            addr_q   <= base_addr & ~ADDR_W'(3);
            remain_q <= word_count;
            sent_q   <= '0;
            if (word_count == '0) begin
              state_q <= ST_FIN;
            end else begin
              state_q   <= ST_ISSUE;
              bram_en_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          wait_q  <= WAIT_INIT;
          state_q <= (RD_LAT == 1) ? ST_LOAD : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == '0) state_q <= ST_LOAD;
          else              wait_q  <= wait_q - 2'd1;
        end
        ST_LOAD: state_q <= ST_SHIFT;
        ST_SHIFT: begin
          if (eoc_hit) begin
            state_q <= ST_FIN;
          end else if (last_byte) begin
            remain_q <= remain_q - CNT_W'(1);
            addr_q   <= addr_q + ADDR_W'(4);
            if (remain_q == CNT_W'(1)) begin
              state_q <= ST_FIN;
            end else begin
              state_q   <= ST_ISSUE;
              bram_en_q <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_codestream_bram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_codestream_bram_reader : directed + random bench with byte model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_codestream_bram_reader;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        bram_en;
  logic [31:0] bram_addr;
  logic [31:0] bram_dout = '0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [17:0] bytes_sent;
`ifdef CODESTREAM_EOC_STOP_EN
  logic        eoc_seen;
`endif

  always #5 clk = ~clk;

  codestream_bram_reader #(.ADDR_W(32), .CNT_W(16), .RD_LAT(RD_LAT)) dut (
    .clk_100    (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done),
`ifdef CODESTREAM_EOC_STOP_EN
    .eoc_seen   (eoc_seen),
`endif
    .bytes_sent (bytes_sent)
  );

  // Word-addressed BRAM model, one-cycle read latency
  bit [31:0] mem [64];
  always @(posedge clk) if (bram_en) bram_dout <= mem[(bram_addr >> 2) % 64];

  int total = 0;
  int bad   = 0;

  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  logic [31:0] addrs[$];
  logic [31:0] exp_addr[$];
  int          xn[$];
  int          done_cnt;
  int          done_n;
  int          first_v;
  bit          exp_eoc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
`ifdef CODESTREAM_EOC_STOP_EN
    return {1'b0, eoc_seen, bram_en, bram_addr, byte_data, byte_valid, busy, done, bytes_sent};
`else
    return {2'b00, bram_en, bram_addr, byte_data, byte_valid, busy, done, bytes_sent};
`endif
  endfunction

  // Reference: list the words the reader should fetch and the bytes it should emit
  task automatic build_exp(input logic [31:0] base, input logic [15:0] cnt);
    logic [31:0] a;
    logic [31:0] wd;
    logic [7:0]  by;
    logic [7:0]  prev;
    bit          stop;
    exp_q.delete();
    exp_addr.delete();
    exp_eoc = 1'b0;
    a    = {base[31:2], 2'b00};
    prev = 8'h00;
    stop = 1'b0;
    for (int w = 0; w < int'(cnt) && !stop; w++) begin
      exp_addr.push_back(a);
      wd = mem[(a >> 2) % 64];
      for (int b = 0; b < 4 && !stop; b++) begin
        by = wd[31 - 8*b -: 8];
        exp_q.push_back(by);
`ifdef CODESTREAM_EOC_STOP_EN
        if (prev == 8'hFF && by == 8'hD9) begin
          exp_eoc = 1'b1;
          stop    = 1'b1;
        end
`endif
        prev = by;
      end
      a = a + 32'd4;
    end
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [15:0] cnt, input int rmode,
                          input bit repulse, input int abort_at);
    bit         prev_stall;
    logic [7:0] prev_data;
    got.delete();
    addrs.delete();
    xn.delete();
    done_cnt   = 0;
    done_n     = -1;
    first_v    = -1;
    prev_stall = 1'b0;
    prev_data  = '0;
    @(posedge clk); #1;
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    byte_ready = (rmode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (prev_stall) chk("stall_hold", {byte_valid, byte_data}, {1'b1, prev_data});
      if (bram_en) addrs.push_back(bram_addr);
      if (byte_valid && first_v < 0) first_v = n;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      start = repulse && (n == 3);
      if (repulse && n == 3) begin
        base_addr  = 32'h40;
        word_count = 16'd5;
      end
      if (abort_at >= 0 && got.size() == abort_at && byte_valid) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_outputs_zero", outs_vec(), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1;
          if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", {busy, bram_en, byte_valid}, 3'b000);
        break;
      end
      byte_ready = (rmode == 0) ? 1'b1 : (($urandom % 3) != 0);
      if (byte_valid && byte_ready) begin
        got.push_back(byte_data);
        xn.push_back(n);
      end
      prev_stall = byte_valid && !byte_ready;
      prev_data  = byte_data;
      if (done_n >= 0 && n >= done_n + 4) break;
    end
    start      = 1'b0;
    byte_ready = 1'b0;
  endtask

  task automatic verify(input string tag);
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, got[i], exp_q[i]);
    chk({tag, "_naddr"}, addrs.size(), exp_addr.size());
    for (int i = 0; i < addrs.size() && i < exp_addr.size(); i++)
      chk({tag, "_addr"}, addrs[i], exp_addr[i]);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_bytes_sent"}, bytes_sent, exp_q.size());
    chk({tag, "_busy_end"}, busy, 1'b0);
`ifdef CODESTREAM_EOC_STOP_EN
    chk({tag, "_eoc_seen"}, eoc_seen, exp_eoc);
`endif
  endtask

  initial begin
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    mem[2] = 32'h5A6B7C8D;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_vec(), 64'd0);
    rst = 1'b0;

    // two words, consumer always ready: order, addresses, latency, rate
    build_exp(32'h0, 16'd2);
    run_xfer(32'h0, 16'd2, 0, 1'b0, -1);
    verify("basic");
    chk("first_valid_lat", first_v + 1, RD_LAT + 2);
    if (xn.size() >= 5) chk("word_rate", xn[4] - xn[0], RD_LAT + 6);
    else chk("word_rate_xfers", xn.size(), 5);

    // same data with random back-pressure
    build_exp(32'h0, 16'd2);
    run_xfer(32'h0, 16'd2, 1, 1'b0, -1);
    verify("stall");

    // empty transfer
    build_exp(32'h0, 16'd0);
    run_xfer(32'h0, 16'd0, 0, 1'b0, -1);
    verify("zero");
    chk("zero_done_lat", done_n + 1, 2);

    // reset mid-word of a three-word transfer, then a clean restart
    run_xfer(32'h0, 16'd3, 0, 1'b0, 5);
    build_exp(32'h8, 16'd1);
    run_xfer(32'h8, 16'd1, 1, 1'b0, -1);
    verify("after_rst");

    // misaligned base plus a re-pulse of start while busy
    build_exp(32'h6, 16'd1);
    run_xfer(32'h6, 16'd1, 0, 1'b1, -1);
    verify("repulse");

`ifdef CODESTREAM_EOC_STOP_EN
    mem[0] = 32'h12FFD934;
    mem[1] = 32'h56789ABC;
    build_exp(32'h0, 16'd2);
    run_xfer(32'h0, 16'd2, 0, 1'b0, -1);
    verify("eoc");
    chk("eoc_flag", eoc_seen, 1'b1);
    chk("eoc_count", bytes_sent, 3);
`endif

    // random data, base, count and back-pressure
    for (int r = 0; r < 4; r++) begin
      logic [31:0] rb;
      logic [15:0] rc;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      rb = $urandom_range(0, 200);
      rc = 16'($urandom_range(1, 4));
      build_exp(rb, rc);
      run_xfer(rb, rc, 1, 1'b0, -1);
      verify("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
